// File: rtl/eq_pkg.sv
// Shared equalizer constants and types used by the gain ramp scheduler.
package eq_pkg;
  localparam int N_BANDS = 10;
  localparam int GAIN_W  = 13;
  localparam int AUDIO_W = 24;
  localparam int BAND_W  = 4;

  localparam logic [7:0] GAIN_BASE_ADDR = 8'h01;

  typedef logic [GAIN_W-1:0] gain_t;

  localparam gain_t RESET_GAIN = 13'h0400;
  localparam gain_t STEP       = 13'd8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } sched_state_e;
endpackage

// File: rtl/gain_ramp_scheduler_if.sv
// Gain bus between the register bank / sample strobe and the scheduler.
interface gain_ramp_scheduler_if;
  import eq_pkg::*;

  logic                      audio_valid;
  logic                      ramp_en;
  logic [N_BANDS*GAIN_W-1:0] target_gain;
  logic [N_BANDS*GAIN_W-1:0] cur_gain;
  logic                      busy;
  logic                      sweep_done;
  logic                      settled;
  logic                      overrun;

  modport master (
    output audio_valid, ramp_en, target_gain,
    input  cur_gain, busy, sweep_done, settled, overrun
  );

  modport slave (
    input  audio_valid, ramp_en, target_gain,
    output cur_gain, busy, sweep_done, settled, overrun
  );
endinterface

// File: rtl/gain_ramp_scheduler_step.sv
// One-band gain step: jump to target, or move toward it by at most step
// without overshooting and without wrapping past either end of the range.
module gain_step_unit
  import eq_pkg::*;
(
  input  gain_t cur_i,
  input  gain_t tgt_i,
  input  gain_t step_i,
  input  logic  ramp_en_i,
  output gain_t nxt_o
);

  logic [GAIN_W:0] up_w;
  logic [GAIN_W:0] dn_w;

  assign up_w = {1'b0, cur_i} + {1'b0, step_i};
  assign dn_w = {1'b0, cur_i} - {1'b0, step_i};

  always_comb begin
    nxt_o = cur_i;
    if (!ramp_en_i) begin
      nxt_o = tgt_i;
    end else if (cur_i < tgt_i) begin
      nxt_o = (up_w > {1'b0, tgt_i}) ? tgt_i : up_w[GAIN_W-1:0];
    end else if (cur_i > tgt_i) begin
      // dn_w[GAIN_W] set means the subtraction went below zero
      nxt_o = (dn_w[GAIN_W] || (dn_w[GAIN_W-1:0] < tgt_i)) ? tgt_i : dn_w[GAIN_W-1:0];
    end
  end

endmodule

// File: rtl/gain_ramp_scheduler.sv
// Per-sample sweep of the band gains through one shared step unit.
//   state    | meaning
//   ST_IDLE  | waiting for an audio_valid rising edge
//   ST_SWEEP | updating band band_q this cycle, one band per clock
module gain_ramp_scheduler
  import eq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  gain_ramp_scheduler_if.slave bus
);

  sched_state_e        state_q;
  logic [BAND_W-1:0]   band_q;
  logic                av_q;
  logic                pending_q;
  logic                busy_q;
  logic                sweep_done_q;
  logic                settled_q;
  logic                overrun_q;
  gain_t               cur_q  [N_BANDS];
  gain_t               snap_q [N_BANDS];

  logic                event_w;
  logic                last_w;
  gain_t               sel_cur_w;
  gain_t               sel_tgt_w;
  gain_t               step_nxt_w;
  logic                settled_d;
  logic [N_BANDS*GAIN_W-1:0] cur_packed_w;

  assign event_w = bus.audio_valid & ~av_q;
  assign last_w  = (band_q == BAND_W'(N_BANDS-1));

  always_comb begin
    sel_cur_w = '0;
    sel_tgt_w = '0;
    for (int b = 0; b < N_BANDS; b++) begin
      if (band_q == BAND_W'(b)) begin
        sel_cur_w = cur_q[b];
        sel_tgt_w = snap_q[b];
      end
    end
  end

  gain_step_unit u_step (
    .cur_i     (sel_cur_w),
    .tgt_i     (sel_tgt_w),
    .step_i    (STEP),
    .ramp_en_i (bus.ramp_en),
    .nxt_o     (step_nxt_w)
  );

  // Only meaningful on the last band: earlier bands already hold this sweep's result.
  always_comb begin
    settled_d = (step_nxt_w == snap_q[N_BANDS-1]);
    for (int b = 0; b < N_BANDS-1; b++) begin
      if (cur_q[b] != snap_q[b]) settled_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      band_q       <= '0;
      av_q         <= 1'b0;
      pending_q    <= 1'b0;
      busy_q       <= 1'b0;
      sweep_done_q <= 1'b0;
      settled_q    <= 1'b1;
      overrun_q    <= 1'b0;
      for (int b = 0; b < N_BANDS; b++) begin
        cur_q[b]  <= RESET_GAIN;
        snap_q[b] <= RESET_GAIN;
      end
    end else begin
      av_q         <= bus.audio_valid;
      sweep_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (event_w) begin
            for (int b = 0; b < N_BANDS; b++) snap_q[b] <= bus.target_gain[b*GAIN_W +: GAIN_W];
            band_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SWEEP;
          end
        end
        ST_SWEEP: begin
          for (int b = 0; b < N_BANDS; b++) begin
            if (band_q == BAND_W'(b)) cur_q[b] <= step_nxt_w;
          end
          if (last_w) begin
            sweep_done_q <= 1'b1;
            settled_q    <= settled_d;
            band_q       <= '0;
            if (pending_q || event_w) begin
              for (int b = 0; b < N_BANDS; b++) snap_q[b] <= bus.target_gain[b*GAIN_W +: GAIN_W];
              // A fresh edge arriving while the queued one is consumed takes its place.
              pending_q <= pending_q & event_w;
            end else begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end else begin
            band_q <= band_q + BAND_W'(1);
            if (event_w) begin
              if (pending_q) overrun_q <= 1'b1;
              else           pending_q <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cur_packed_w = '0;
    for (int b = 0; b < N_BANDS; b++) cur_packed_w[b*GAIN_W +: GAIN_W] = cur_q[b];
  end

  assign bus.cur_gain   = cur_packed_w;
  assign bus.busy       = busy_q;
  assign bus.sweep_done = sweep_done_q;
  assign bus.settled    = settled_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_gain_ramp_scheduler.sv
// Bench for gain_ramp_scheduler: sample-level reference model plus directed literal checks.
module tb_gain_ramp_scheduler;
  import eq_pkg::*;

  localparam int NB = 10;
  localparam int GW = 13;
  localparam int TW = NB*GW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  gain_ramp_scheduler_if bus();

  gain_ramp_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int nvec     = 0;
  int nmis     = 0;
  int done_cnt = 0;
  bit chk_en   = 1'b0;

  // Reference model state
  int mcur  [NB] = '{default: 1024};
  int msnap [NB] = '{default: 1024};
  bit mbusy = 1'b0, mdone = 1'b0, mset = 1'b1, mov = 1'b0, mpend = 1'b0, mav = 1'b0;
  int mpos  = 0;

  function automatic int mstep(int c, int t, bit r);
    if (!r)    return t;
    if (c < t) return (c + 8 < t) ? c + 8 : t;
    if (c > t) return (c - 8 > t) ? c - 8 : t;
    return c;
  endfunction

  function automatic logic [TW-1:0] pack_model();
    logic [TW-1:0] v;
    v = '0;
    for (int b = 0; b < NB; b++) v[b*GW +: GW] = GW'(mcur[b]);
    return v;
  endfunction

  function automatic logic [GW-1:0] band(int b);
    return bus.cur_gain[b*GW +: GW];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit ev;
    bit all_eq;
    if (!rst_n) begin
      for (int b = 0; b < NB; b++) begin
        mcur[b]  = 1024;
        msnap[b] = 1024;
      end
      mbusy = 0; mdone = 0; mset = 1; mov = 0; mpend = 0; mav = 0; mpos = 0;
    end else begin
      ev    = bus.audio_valid && !mav;
      mav   = bus.audio_valid;
      mdone = 0;
      if (!mbusy) begin
        if (ev) begin
          for (int b = 0; b < NB; b++) msnap[b] = int'(bus.target_gain[b*GW +: GW]);
          mpos  = 0;
          mbusy = 1;
        end
      end else begin
        mcur[mpos] = mstep(mcur[mpos], msnap[mpos], bus.ramp_en);
        if (mpos == NB-1) begin
          mdone  = 1;
          all_eq = 1;
          for (int b = 0; b < NB; b++) if (mcur[b] != msnap[b]) all_eq = 0;
          mset = all_eq;
          if (mpend || ev) begin
            for (int b = 0; b < NB; b++) msnap[b] = int'(bus.target_gain[b*GW +: GW]);
            mpend = mpend && ev;
            mpos  = 0;
          end else begin
            mbusy = 0;
          end
        end else begin
          mpos++;
          if (ev) begin
            if (mpend) mov = 1;
            else       mpend = 1;
          end
        end
      end
    end
  end

  task automatic chk(string nm, logic [TW-1:0] act, logic [TW-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cur_gain",   bus.cur_gain,         pack_model());
      chk("busy",       TW'(bus.busy),       TW'(mbusy));
      chk("sweep_done", TW'(bus.sweep_done), TW'(mdone));
      chk("settled",    TW'(bus.settled),    TW'(mset));
      chk("overrun",    TW'(bus.overrun),    TW'(mov));
      if (bus.sweep_done) done_cnt++;
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse();
    bus.audio_valid = 1'b1;
    @(negedge clk);
    bus.audio_valid = 1'b0;
  endtask

  task automatic set_all(int v);
    for (int b = 0; b < NB; b++) bus.target_gain[b*GW +: GW] = GW'(v);
  endtask

  initial begin
    int d0;
    logic [TW-1:0] exp_v;
    bus.audio_valid = 1'b0;
    bus.ramp_en     = 1'b0;
    set_all(1024);
    tick(3);
    chk_en = 1'b1;
    chk("rst_cur",     bus.cur_gain, {NB{13'h0400}});
    chk("rst_settled", TW'(bus.settled), TW'(1));
    chk("rst_busy",    TW'(bus.busy),    TW'(0));
    #2 rst_n = 1'b1;
    tick(2);
    chk("idle_cur",    bus.cur_gain, {NB{13'h0400}});

    // Jump mode, targets 17..26
    for (int b = 0; b < NB; b++) bus.target_gain[b*GW +: GW] = GW'(17 + b);
    d0 = done_cnt;
    pulse();
    tick(12);
    for (int b = 0; b < NB; b++) chk($sformatf("jump_b%0d", b), TW'(band(b)), TW'(17 + b));
    chk("jump_done_cnt", TW'(done_cnt - d0), TW'(1));
    chk("jump_settled",  TW'(bus.settled),   TW'(1));

    // Clamp boundaries: small step down, top of range, bottom of range
    set_all(1024);
    bus.target_gain[1*GW +: GW] = 13'h1FFC;
    bus.target_gain[2*GW +: GW] = 13'd5;
    pulse();
    tick(12);
    bus.ramp_en = 1'b1;
    set_all(1024);
    bus.target_gain[0*GW +: GW] = 13'h03FC;
    bus.target_gain[1*GW +: GW] = 13'h1FFF;
    bus.target_gain[2*GW +: GW] = 13'd0;
    pulse();
    tick(12);
    chk("clamp_dn_b0",  TW'(band(0)), TW'(13'h03FC));
    chk("clamp_top_b1", TW'(band(1)), TW'(13'h1FFF));
    chk("clamp_bot_b2", TW'(band(2)), TW'(0));
    chk("clamp_settled", TW'(bus.settled), TW'(1));

    // Ramp 0x400 -> 0x420 in four sweeps
    bus.ramp_en = 1'b0;
    set_all(1024);
    pulse();
    tick(12);
    bus.ramp_en = 1'b1;
    bus.target_gain[0*GW +: GW] = 13'h0420;
    for (int s = 1; s <= 4; s++) begin
      pulse();
      tick(12);
      chk($sformatf("ramp_b0_s%0d", s),  TW'(band(0)),     TW'(1024 + 8*s));
      chk($sformatf("ramp_set_s%0d", s), TW'(bus.settled), TW'(s == 4));
    end

    // Held level is a single event
    d0 = done_cnt;
    bus.audio_valid = 1'b1;
    tick(5);
    bus.audio_valid = 1'b0;
    tick(15);
    chk("held_done_cnt", TW'(done_cnt - d0), TW'(1));

    // One queued event restarts the sweep
    bus.ramp_en = 1'b0;
    d0 = done_cnt;
    pulse();
    tick(2);
    pulse();
    tick(25);
    chk("queue_done_cnt", TW'(done_cnt - d0), TW'(2));
    chk("queue_overrun",  TW'(bus.overrun),   TW'(0));

    // Third edge in one sweep is lost
    d0 = done_cnt;
    pulse();
    tick(2);
    pulse();
    tick(2);
    pulse();
    tick(25);
    chk("ovr_done_cnt", TW'(done_cnt - d0), TW'(2));
    chk("ovr_set",      TW'(bus.overrun),   TW'(1));
    tick(30);
    chk("ovr_sticky",   TW'(bus.overrun),   TW'(1));

    // Mid-sweep target change waits for the next event
    for (int b = 0; b < NB; b++) bus.target_gain[b*GW +: GW] = GW'(100 + b);
    pulse();
    tick(3);
    for (int b = 0; b < NB; b++) bus.target_gain[b*GW +: GW] = GW'(200 + b);
    tick(12);
    for (int b = 0; b < NB; b++) exp_v[b*GW +: GW] = GW'(100 + b);
    chk("snap_old", bus.cur_gain, exp_v);
    pulse();
    tick(12);
    for (int b = 0; b < NB; b++) exp_v[b*GW +: GW] = GW'(200 + b);
    chk("snap_new", bus.cur_gain, exp_v);

    // Reset during band 5
    set_all(13'h0123);
    pulse();
    tick(5);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_cur",     bus.cur_gain,      {NB{13'h0400}});
    chk("midrst_busy",    TW'(bus.busy),     TW'(0));
    chk("midrst_overrun", TW'(bus.overrun),  TW'(0));
    #2 rst_n = 1'b1;
    tick(2);
    pulse();
    tick(12);
    chk("postrst_cur", bus.cur_gain, {NB{13'h0123}});

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
